// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at issue into shadow registers and committed after a fixed latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic          sh_we_q, sh_we_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dividend, divisor, q_u, r_u, quotient, remainder;

    always_comb begin
        mul_signed = (op == OP_MULT);
        mul_a      = {{32{mul_signed & operand_a[31]}}, operand_a};
        mul_b      = {{32{mul_signed & operand_b[31]}}, operand_b};
        product    = mul_a * mul_b;
    end

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & operand_a[31];
        b_neg      = div_signed & operand_b[31];
        a_mag      = a_neg ? (32'd0 - operand_a) : operand_a;
        b_mag      = b_neg ? (32'd0 - operand_b) : operand_b;
        dividend   = a_mag;
        divisor    = (operand_b == '0) ? 32'd1 : b_mag;
        q_u        = dividend / divisor;
        r_u        = dividend % divisor;
        quotient   = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        remainder  = a_neg ? (32'd0 - r_u) : r_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_we_d = sh_we_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {sh_hi_d, sh_lo_d} = product;
                            sh_we_d            = 1'b1;
                            cnt_d              = CW'(MULT_CYCLES);
                            state_d            = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            sh_hi_d = remainder;
                            sh_lo_d = quotient;
                            sh_we_d = (operand_b != '0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = operand_a;
                        OP_MTLO: lo_d = operand_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (sh_we_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_we_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_we_q <= sh_we_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: default latencies plus a 1-cycle override instance.
module tb_mult_div_unit;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, RSVD = 3'd7;

    logic        clk, reset, start, start1;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, busy1;
    logic [31:0] hi, lo, hi1, lo1;

    int n_vec = 0;
    int n_err = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy1), .hi(hi1), .lo(lo1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cur_busy(input bit sel);
        return sel ? busy1 : busy;
    endfunction

    // Issue one op, scramble operands during BUSY, then check latency and HI/LO.
    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh, input logic [31:0] el, input string tag);
        int cyc;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start = 1'b1;
        op = o; operand_a = a; operand_b = b;
        #1 check({tag, "_busy_pre"}, 64'(cur_busy(sel)), 64'd0);
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        cyc = 0;
        while (cur_busy(sel) && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 64'(cyc), 64'(n));
        check({tag, "_hi"}, 64'(sel ? hi1 : hi), 64'(eh));
        check({tag, "_lo"}, 64'(sel ? lo1 : lo), 64'(el));
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cyc, k;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        move(MTHI, 32'hAAAA5555);
        check("mthi_hi", 64'(hi), 64'hAAAA5555);
        check("mthi_busy", 64'(busy), 64'd0);
        move(MTLO, 32'h12345678);
        check("mtlo_lo", 64'(lo), 64'h12345678);
        check("mtlo_hi", 64'(hi), 64'hAAAA5555);

        // Reset two cycles into a MULT, asserted between edges.
        @(negedge clk);
        start = 1'b1; op = MULT; operand_a = 32'd5; operand_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hi", 64'(hi), 64'd0);
        check("rstmid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_idle", 64'(busy), 64'd0);
        run_op(0, DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu_7_2");

        run_op(0, MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_m2x3");
        run_op(0, MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu_fffe_x3");
        run_op(0, DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
        run_op(0, DIV,   32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, "div_7_m2");
        run_op(0, DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "div_ovf");

        move(MTHI, 32'h11111111);
        move(MTLO, 32'h22222222);
        run_op(0, DIVU, 32'd5, 32'd0, 10, 32'h11111111, 32'h22222222, "divu_by0");
        run_op(0, DIV, 32'hFFFFFFFB, 32'd0, 10, 32'h11111111, 32'h22222222, "div_by0");

        move(RSVD, 32'hCAFEF00D);
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_hi", 64'(hi), 64'h11111111);
        check("rsvd_lo", 64'(lo), 64'h22222222);

        // MULT 3x4 with MTLO and DIV presented while busy.
        @(negedge clk);
        start = 1'b1; op = MULT; operand_a = 32'd3; operand_b = 32'd4;
        @(negedge clk);
        cyc = 0; k = 0;
        while (busy && cyc < 64) begin
            cyc++;
            if (k == 0) begin
                op = MTLO; operand_a = 32'h0000DEAD; operand_b = '0;
                check("busy_hold_hi", 64'(hi), 64'h11111111);
                check("busy_hold_lo", 64'(lo), 64'h22222222);
            end else if (k == 1) begin
                op = DIV; operand_a = 32'd9; operand_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("sbusy_cycles", 64'(cyc), 64'd5);
        check("sbusy_hi", 64'(hi), 64'd0);
        check("sbusy_lo", 64'(lo), 64'd12);
        start = 1'b1; op = MTLO; operand_a = 32'h0000DEAD; operand_b = '0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_mtlo_lo", 64'(lo), 64'h0000DEAD);
        check("b2b_mtlo_hi", 64'(hi), 64'd0);
        check("b2b_mtlo_busy", 64'(busy), 64'd0);

        run_op(1, MULT, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, "p1_mult");
        run_op(1, DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, "p1_divu");
        run_op(1, MULTU, 32'h00010000, 32'h00010000, 1, 32'd1, 32'd0, "p1_multu");
        check("p1_main_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file, beside the ALU. It consumes the same two operands the ALU receives (rs value and rt value) and holds the 64-bit products and quotient/remainder pairs that MFHI/MFLO later read back into the register file. Busy is exported so the controller or hazard logic can stall any MDU instruction that issues while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue strobe for the op on `op` this cycle
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (no-op)
- operand_a  input  32  rs value (multiplicand / dividend / MTHI-MTLO source)
- operand_b  input  32  rt value (multiplier / divisor)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Two-state FSM with states IDLE and BUSY. A down-counter `cnt` has width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- IDLE with start=1 and op ∈ {MULT, MULTU, DIV, DIVU}:
  - Compute the 64-bit result from operand_a/operand_b and latch it into shadow registers {sh_hi, sh_lo}.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to BUSY.
- IDLE with start=1 and op=MTHI: hi ← operand_a at this edge, no BUSY. op=MTLO: lo ← operand_a at this edge, no BUSY.
- IDLE with start=1 and op=6/7: no state change.
- BUSY: cnt decrements each edge. On the edge where cnt==1: hi ← sh_hi, lo ← sh_lo, go to IDLE.
- In BUSY, start is ignored for every op. Hazard logic must stall; the unit does not queue.
- Arithmetic:
  - MULT: {hi,lo} = signed(a)×signed(b), full 64 bits.
  - MULTU: the same product, unsigned.
  - DIV: lo = quotient truncated toward zero, hi = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - DIV/DIVU with b=0: the unit still goes BUSY for DIV_CYCLES, but hi/lo keep their previous values at completion. The shadow-write enable is cleared at issue.
- hi/lo change only at the completion edge, MTHI/MTLO, or reset. The shadow registers are never visible on the outputs.

## Timing
- Reset values: busy=0, hi=0, lo=0, state=IDLE, cnt=0, shadows=0. Reset takes effect immediately, without waiting for clk.
- Reset asserted in BUSY aborts the operation. No partial HI/LO update occurs, and after reset deasserts the unit is IDLE.
- Issue at edge T0 gives busy=1 from just after T0 to just after T0+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
- hi/lo show the new value after edge T0+N, and busy falls on that same edge.
- A new start in the cycle after busy falls is accepted, so back-to-back ops issue every N+1 cycles at best.
- busy is a registered output with no combinational path from start.
- MTHI/MTLO latency is 1 edge.
- Operands are sampled only at the issue edge. Changes during BUSY have no effect.

## Test plan
- Reset mid-op: MULT issued, reset asserted 2 cycles later between clock edges → busy=0, hi=lo=0 immediately. After release, a DIVU 7/2 completes normally with lo=3, hi=1.
- MULT signed: a=0xFFFFFFFE (−2), b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV sign rules: a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Overflow case a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11111111 and lo=0x22222222 via MTHI/MTLO, then DIVU a=5, b=0 → busy for 10 cycles, then hi/lo unchanged.
- Start while busy: MULT 3×4 issued, then MTLO 0xDEAD and DIV 9/3 presented on the next 2 cycles → both ignored, final hi=0, lo=12. MTLO 0xDEAD issued right after busy falls → lo=0xDEAD after 1 edge.
- Parameter override: instantiate with MULT_CYCLES=1 and DIV_CYCLES=1 → busy high for exactly one cycle per op, and results are correct.
